decoder_5to32: RTL and testbench
================================

DECODER_5TO32 -- requirements
Module: decoder_5to32

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW_OUT, default 0: 0 = selected output bit is 1, others 0; 1 = all polarities inverted.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port Enable, input, 1 bit: decode enable, active-high.
REQ-005 The block SHALL have port A, input, 5 bits: binary select, A[4] is the MSB.
REQ-006 The block SHALL have port D, output, 32 bits: registered one-hot decode, bit index equal to the value of A.
REQ-007 The block SHALL have no other ports; clock and reset are the only timing inputs.

Function
REQ-008 On each rising clk edge with rst_n=1 and Enable=1, D SHALL load the one-hot word with only bit A set; all other 31 bits clear.
REQ-009 On each rising clk edge with rst_n=1 and Enable=0, D SHALL load all zeros.
REQ-010 Latency SHALL be exactly one clock from the A/Enable sample edge to D; there is no combinational path from A or Enable to D.
REQ-011 D SHALL be one-hot or all-zero at every clock edge, never multi-hot.
REQ-012 Boundaries: A=0 SHALL set D[0] only; A=31 SHALL set D[31] only; no wrap or out-of-range case exists.
REQ-013 A changing every cycle SHALL produce a new decode every cycle, with no hold-off or handshake.
REQ-014 With ACTIVE_LOW_OUT=1, D SHALL equal the bitwise inverse of the ACTIVE_LOW_OUT=0 value in every case, including reset and disable.
REQ-015 X or Z on A while Enable=1 is out of contract; the block need not define D in that case.

Reset
REQ-016 While rst_n=0 at a rising clk edge, D SHALL load the inactive value (all zeros; all ones if ACTIVE_LOW_OUT=1), regardless of Enable and A.
REQ-017 Reset SHALL take priority over Enable.
REQ-018 Reset asserted mid-operation SHALL clear D at the next edge.
REQ-019 After reset deasserts, the first edge SHALL produce a normal decode.
REQ-020 D SHALL NOT change between clock edges when rst_n changes.

Structure
REQ-021 Width constants SHALL live in a shared package decoder_pkg: SEL_W=5 and OUT_W=32.
REQ-022 The decode SHALL be built from a 2-to-4 predecode of A[4:3], gating four instances of sub-module decoder_3to8 (3-bit select, enable, 8-bit one-hot out) driven by A[2:0].
REQ-023 The four 8-bit instance outputs SHALL be concatenated with A[4:3]=0 mapping to D[7:0].
REQ-024 A single output register stage SHALL apply reset and polarity.

Verification
REQ-025 rst_n=0 for 2 cycles, Enable=1, A=5'b00101 -> D=32'h0000_0000; at the first edge after rst_n=1, D=32'h0000_0020.
REQ-026 Enable=1, A sequence 1, 2, 3 on consecutive edges -> D=32'h0000_0002, 32'h0000_0004, 32'h0000_0008, each one cycle after its A.
REQ-027 Enable=1, A=0 then A=31 -> D=32'h0000_0001, then 32'h8000_0000.
REQ-028 Enable=0, A=5'd17 -> D=32'h0000_0000; Enable returned to 1 -> D=32'h0002_0000 next cycle.
REQ-029 Exhaustive sweep of A=0..31 with Enable=1 -> D==1<<A each cycle, and the popcount of D is 1.
REQ-030 ACTIVE_LOW_OUT=1, A=5'd4, Enable=1 -> D=32'hFFFF_FFEF; during reset -> D=32'hFFFF_FFFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared width constants and the select predecode helper for the
// 5-to-32 registered decoder.
package decoder_pkg;

  localparam int unsigned SEL_W = 5;
  localparam int unsigned OUT_W = 32;

  // Upper select bits split the output into four 8-bit groups.
  localparam int unsigned GRP_W   = 8;
  localparam int unsigned GRP_NUM = OUT_W / GRP_W;

  // 2-to-4 one-hot predecode of the group select bits.
  function automatic logic [GRP_NUM-1:0] predecode_2to4(input logic [1:0] sel);
    logic [GRP_NUM-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
//   sel_i : 3-bit binary select
//   en_i  : active-high enable; when low the output is all zeros
//   dec_o : 8-bit one-hot output, bit index equal to sel_i
module decoder_3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_5to32.sv
// Registered 5-to-32 one-hot decoder.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, loads the inactive output value
//   Enable : active-high decode enable
//   A      : 5-bit binary select, A[4] is the MSB
//   D      : registered one-hot decode (inverted when ACTIVE_LOW_OUT = 1)
module decoder_5to32
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Enable,
  input  logic [SEL_W-1:0] A,
  output logic [OUT_W-1:0] D
);

  logic [GRP_NUM-1:0] grp_en;
  logic [OUT_W-1:0]   dec_w;
  logic [OUT_W-1:0]   d_d;
  logic [OUT_W-1:0]   d_q;

  // Enable is folded into the group predecode so a disabled cycle yields
  // all zeros from every 3-to-8 instance.
  always_comb begin
    grp_en = '0;
    if (Enable) begin
      grp_en = predecode_2to4(A[4:3]);
    end
  end

  // Group g drives D[8g+7:8g]; A[4:3] = 0 maps to D[7:0].
  for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
    decoder_3to8 u_dec (
      .sel_i (A[2:0]),
      .en_i  (grp_en[g]),
      .dec_o (dec_w[g*GRP_W +: GRP_W])
    );
  end

  always_comb begin
    d_d = dec_w;
    if (ACTIVE_LOW_OUT) begin
      d_d = ~dec_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= ACTIVE_LOW_OUT ? '1 : '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign D = d_q;

endmodule

// File: tb/tb_decoder_5to32.sv
module tb_decoder_5to32;

  logic        clk;
  logic        rst_n;
  logic        Enable;
  logic [4:0]  A;
  logic [31:0] D;
  logic [31:0] D_inv;

  int total;
  int bad;

  decoder_5to32 #(.ACTIVE_LOW_OUT(1'b0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Enable (Enable),
    .A      (A),
    .D      (D)
  );

  decoder_5to32 #(.ACTIVE_LOW_OUT(1'b1)) dut_inv (
    .clk    (clk),
    .rst_n  (rst_n),
    .Enable (Enable),
    .A      (A),
    .D      (D_inv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    Enable = 1'b1;
    A      = 5'b00101;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (D !== 32'h0000_0000) begin
        bad++;
        $display("FAIL reset_d cyc=%0d got=%h exp=%h", i, D, 32'h0000_0000);
      end
      total++;
      if (D_inv !== 32'hFFFF_FFFF) begin
        bad++;
        $display("FAIL reset_dinv cyc=%0d got=%h exp=%h", i, D_inv, 32'hFFFF_FFFF);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (D !== 32'h0000_0020) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", D, 32'h0000_0020);
    end
    total++;
    if (D_inv !== 32'hFFFF_FFDF) begin
      bad++;
      $display("FAIL reset_release_inv got=%h exp=%h", D_inv, 32'hFFFF_FFDF);
    end
  endtask

  task automatic test_sequence();
    Enable = 1'b1;
    A = 5'd1;
    tick();
    total++;
    if (D !== 32'h0000_0002) begin
      bad++;
      $display("FAIL seq_a1 got=%h exp=%h", D, 32'h0000_0002);
    end
    A = 5'd2;
    #1;
    // A changed between edges: D must still hold the previous decode.
    total++;
    if (D !== 32'h0000_0002) begin
      bad++;
      $display("FAIL seq_no_comb got=%h exp=%h", D, 32'h0000_0002);
    end
    tick();
    total++;
    if (D !== 32'h0000_0004) begin
      bad++;
      $display("FAIL seq_a2 got=%h exp=%h", D, 32'h0000_0004);
    end
    A = 5'd3;
    tick();
    total++;
    if (D !== 32'h0000_0008) begin
      bad++;
      $display("FAIL seq_a3 got=%h exp=%h", D, 32'h0000_0008);
    end
  endtask

  task automatic test_boundaries();
    Enable = 1'b1;
    A = 5'd0;
    tick();
    total++;
    if (D !== 32'h0000_0001) begin
      bad++;
      $display("FAIL bound_a0 got=%h exp=%h", D, 32'h0000_0001);
    end
    A = 5'd31;
    tick();
    total++;
    if (D !== 32'h8000_0000) begin
      bad++;
      $display("FAIL bound_a31 got=%h exp=%h", D, 32'h8000_0000);
    end
    total++;
    if (D_inv !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL bound_a31_inv got=%h exp=%h", D_inv, 32'h7FFF_FFFF);
    end
  endtask

  task automatic test_enable();
    Enable = 1'b0;
    A = 5'd17;
    tick();
    total++;
    if (D !== 32'h0000_0000) begin
      bad++;
      $display("FAIL en_off got=%h exp=%h", D, 32'h0000_0000);
    end
    total++;
    if (D_inv !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL en_off_inv got=%h exp=%h", D_inv, 32'hFFFF_FFFF);
    end
    Enable = 1'b1;
    tick();
    total++;
    if (D !== 32'h0002_0000) begin
      bad++;
      $display("FAIL en_on got=%h exp=%h", D, 32'h0002_0000);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    Enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A = i[4:0];
      exp = 32'd1 << i;
      tick();
      total++;
      if (D !== exp) begin
        bad++;
        $display("FAIL sweep a=%0d got=%h exp=%h", i, D, exp);
      end
      total++;
      if ($countones(D) != 1) begin
        bad++;
        $display("FAIL sweep_pop a=%0d got=%0d exp=1", i, $countones(D));
      end
      total++;
      if (D_inv !== ~exp) begin
        bad++;
        $display("FAIL sweep_inv a=%0d got=%h exp=%h", i, D_inv, ~exp);
      end
    end
  endtask

  task automatic test_active_low();
    Enable = 1'b1;
    A = 5'd4;
    tick();
    total++;
    if (D_inv !== 32'hFFFF_FFEF) begin
      bad++;
      $display("FAIL alow_a4 got=%h exp=%h", D_inv, 32'hFFFF_FFEF);
    end
    // Reset asserted between edges must not disturb D until the next edge.
    rst_n = 1'b0;
    #1;
    total++;
    if (D_inv !== 32'hFFFF_FFEF) begin
      bad++;
      $display("FAIL alow_rst_async got=%h exp=%h", D_inv, 32'hFFFF_FFEF);
    end
    total++;
    if (D !== 32'h0000_0010) begin
      bad++;
      $display("FAIL rst_async got=%h exp=%h", D, 32'h0000_0010);
    end
    tick();
    total++;
    if (D_inv !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL alow_rst got=%h exp=%h", D_inv, 32'hFFFF_FFFF);
    end
    total++;
    if (D !== 32'h0000_0000) begin
      bad++;
      $display("FAIL mid_rst got=%h exp=%h", D, 32'h0000_0000);
    end
    A = 5'd9;
    rst_n = 1'b1;
    tick();
    total++;
    if (D !== 32'h0000_0200) begin
      bad++;
      $display("FAIL post_rst got=%h exp=%h", D, 32'h0000_0200);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    Enable = 1'b0;
    A      = '0;
    test_reset();
    test_sequence();
    test_boundaries();
    test_enable();
    test_sweep();
    test_active_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
